// File: rtl/register_file_mp.sv
// register_file_mp
//   Multi-port integer register file with a per-register busy scoreboard.
//   NUM_RD registered read ports with write bypass, two write ports where
//   port 1 wins on an address collision. Optional hardwired-zero register 0.
//
// Ports:
//   i_clk, i_rst_n     clock (rising edge), asynchronous active-low reset
//   i_rd_en            capture every read port on this edge
//   i_rd_addr          read addresses, port k = [k*RA_W +: RA_W]
//   o_rd_data          registered read data, port k = [k*DATA_W +: DATA_W]
//   o_rd_busy          registered busy flag per read port
//   o_rd_valid         o_rd_data/o_rd_busy were updated by the previous edge
//   i_wr0_*            write port 0 (lower priority)
//   i_wr1_*            write port 1 (higher priority)
//   i_busy_set_*       mark a destination register as pending writeback
//   i_flush            clear every busy bit
module register_file_mp #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_rd_en,
  input  logic [NUM_RD*RA_W-1:0]   i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  output logic                     o_rd_valid,
  input  logic                     i_wr0_en,
  input  logic [RA_W-1:0]          i_wr0_addr,
  input  logic [DATA_W-1:0]        i_wr0_data,
  input  logic                     i_wr1_en,
  input  logic [RA_W-1:0]          i_wr1_addr,
  input  logic [DATA_W-1:0]        i_wr1_data,
  input  logic                     i_busy_set_en,
  input  logic [RA_W-1:0]          i_busy_set_addr,
  input  logic                     i_flush
);

  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic [DATA_W-1:0]        regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]      busy_q, busy_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;
  logic                     rd_valid_q, rd_valid_d;

  // Request hits register a; register 0 is never hit when it is hardwired.
  function automatic logic hit(input logic en, input logic [RA_W-1:0] req_a,
                               input logic [RA_W-1:0] a);
    return en && (req_a == a) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    logic [RA_W-1:0]   ra;
    logic [DATA_W-1:0] eff;
    logic              eff_busy;

    regs_d     = regs_q;
    busy_d     = busy_q;
    rd_data_d  = rd_data_q;
    rd_busy_d  = rd_busy_q;
    rd_valid_d = i_rd_en;
    ra         = '0;
    eff        = '0;
    eff_busy   = 1'b0;

    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (hit(i_wr0_en, i_wr0_addr, RA_W'(i))) regs_d[i] = i_wr0_data;
      if (hit(i_wr1_en, i_wr1_addr, RA_W'(i))) regs_d[i] = i_wr1_data;

      if (i_flush)
        busy_d[i] = 1'b0;
      else if (hit(i_busy_set_en, i_busy_set_addr, RA_W'(i)))
        busy_d[i] = 1'b1;
      else if (hit(i_wr0_en, i_wr0_addr, RA_W'(i)) || hit(i_wr1_en, i_wr1_addr, RA_W'(i)))
        busy_d[i] = 1'b0;
    end

    // Read bypass: same-cycle writes are visible and clear busy; a same-cycle
    // busy set is deliberately not visible (the reader precedes the producer).
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra       = i_rd_addr[k*RA_W +: RA_W];
      eff      = regs_q[ra];
      eff_busy = busy_q[ra];
      if (hit(i_wr0_en, i_wr0_addr, ra)) begin
        eff      = i_wr0_data;
        eff_busy = 1'b0;
      end
      if (hit(i_wr1_en, i_wr1_addr, ra)) begin
        eff      = i_wr1_data;
        eff_busy = 1'b0;
      end
      if (i_flush) eff_busy = 1'b0;
      if ((ZERO_REG != 0) && (ra == '0)) begin
        eff      = '0;
        eff_busy = 1'b0;
      end
      if (i_rd_en) begin
        rd_data_d[k*DATA_W +: DATA_W] = eff;
        rd_busy_d[k]                  = eff_busy;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      regs_q     <= '{default: '0};
      busy_q     <= '0;
      rd_data_q  <= '0;
      rd_busy_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      rd_data_q  <= rd_data_d;
      rd_busy_q  <= rd_busy_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_busy  = rd_busy_q;
  assign o_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp
//   Directed bench for register_file_mp (2 read ports, 64-bit, ZERO_REG=1).
//   Stimulus pushes the hand-computed read result into a queue; a monitor
//   pops and compares whenever o_rd_valid is presented.
module tb_register_file_mp;
  localparam int unsigned DW = 64;
  localparam int unsigned RW = 5;
  localparam int unsigned NR = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rd_en;
  logic [NR*RW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              rd_valid;
  logic              wr0_en, wr1_en, set_en, flush;
  logic [RW-1:0]     wr0_addr, wr1_addr, set_addr;
  logic [DW-1:0]     wr0_data, wr1_data;

  always #5 clk = ~clk;

  register_file_mp #(
    .DATA_W(DW), .NUM_REGS(32), .RA_W(RW), .NUM_RD(NR), .ZERO_REG(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_rd_busy(rd_busy), .o_rd_valid(rd_valid),
    .i_wr0_en(wr0_en), .i_wr0_addr(wr0_addr), .i_wr0_data(wr0_data),
    .i_wr1_en(wr1_en), .i_wr1_addr(wr1_addr), .i_wr1_data(wr1_data),
    .i_busy_set_en(set_en), .i_busy_set_addr(set_addr), .i_flush(flush)
  );

  typedef struct {
    string       name;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [1:0]  busy;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle();
    rd_en = 1'b0; rd_addr = '0;
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    set_en = 1'b0; set_addr = '0; flush = 1'b0;
  endtask

  task automatic rd(input string name, input logic [RW-1:0] a0, input logic [RW-1:0] a1,
                    input logic [63:0] d0, input logic [63:0] d1, input logic [1:0] busy);
    exp_t e;
    rd_en   = 1'b1;
    rd_addr = {a1, a0};
    e.name = name; e.d0 = d0; e.d1 = d1; e.busy = busy;
    sb.push_back(e);
  endtask

  task automatic wr0(input logic [RW-1:0] a, input logic [63:0] d);
    wr0_en = 1'b1; wr0_addr = a; wr0_data = d;
  endtask

  task automatic wr1(input logic [RW-1:0] a, input logic [63:0] d);
    wr1_en = 1'b1; wr1_addr = a; wr1_data = d;
  endtask

  task automatic bset(input logic [RW-1:0] a);
    set_en = 1'b1; set_addr = a;
  endtask

  // Monitor: sample one time unit after the active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid with empty queue, required no valid");
      end else begin
        e = sb.pop_front();
        check({e.name, "_d0"}, {64'h0, rd_data[63:0]}, {64'h0, e.d0});
        check({e.name, "_d1"}, {64'h0, rd_data[127:64]}, {64'h0, e.d1});
        check({e.name, "_busy"}, {126'h0, rd_busy}, {126'h0, e.busy});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    repeat (2) @(negedge clk);
    check("rst_valid", {127'h0, rd_valid}, 128'h0);
    check("rst_data", rd_data, 128'h0);
    check("rst_busy", {126'h0, rd_busy}, 128'h0);
    rst_n = 1'b1;

    idle(); rd("after_rst", 5'd3, 5'd7, 64'h0, 64'h0, 2'b00);             @(negedge clk);
    idle(); wr0(5'd5, 64'hA5);                                              @(negedge clk);
    idle(); rd("r5_a5", 5'd5, 5'd5, 64'hA5, 64'hA5, 2'b00);                 @(negedge clk);
    idle(); wr1(5'd5, 64'h11); wr0(5'd5, 64'h22);
            rd("wr_prio_bypass", 5'd5, 5'd3, 64'h11, 64'h0, 2'b00);         @(negedge clk);
    idle(); rd("r5_stored", 5'd5, 5'd5, 64'h11, 64'h11, 2'b00);             @(negedge clk);
    idle(); wr0(5'd10, 64'h1010); wr1(5'd11, 64'h1111);
            rd("dual_wr_bypass", 5'd10, 5'd11, 64'h1010, 64'h1111, 2'b00);  @(negedge clk);
    idle(); rd("dual_wr_stored", 5'd11, 5'd10, 64'h1111, 64'h1010, 2'b00);  @(negedge clk);
    // Hardwired zero register.
    idle(); wr0(5'd0, 64'hFFFF); bset(5'd0);                                @(negedge clk);
    idle(); wr1(5'd0, 64'h77);
            rd("zero_reg", 5'd0, 5'd0, 64'h0, 64'h0, 2'b00);                @(negedge clk);
    // Busy scoreboard.
    idle(); bset(5'd9);                                                     @(negedge clk);
    idle(); rd("r9_busy", 5'd9, 5'd5, 64'h0, 64'h11, 2'b01);                @(negedge clk);
    idle(); wr0(5'd9, 64'h9);
            rd("wb_bypass", 5'd9, 5'd9, 64'h9, 64'h9, 2'b00);               @(negedge clk);
    idle(); bset(5'd9); wr0(5'd9, 64'h99);
            rd("set_and_wb", 5'd9, 5'd9, 64'h99, 64'h99, 2'b00);            @(negedge clk);
    idle(); rd("set_wins", 5'd9, 5'd5, 64'h99, 64'h11, 2'b01);              @(negedge clk);
    idle(); bset(5'd12);
            rd("set_not_seen", 5'd12, 5'd12, 64'h0, 64'h0, 2'b00);          @(negedge clk);
    idle(); rd("two_busy", 5'd12, 5'd9, 64'h0, 64'h99, 2'b11);              @(negedge clk);
    // Flush.
    idle(); bset(5'd4);                                                     @(negedge clk);
    idle(); bset(5'd6);
            rd("pre_flush", 5'd4, 5'd6, 64'h0, 64'h0, 2'b01);               @(negedge clk);
    idle(); flush = 1'b1; bset(5'd8);
            rd("flush_cycle", 5'd4, 5'd6, 64'h0, 64'h0, 2'b00);             @(negedge clk);
    idle(); rd("post_flush", 5'd8, 5'd9, 64'h0, 64'h99, 2'b00);             @(negedge clk);
    idle(); rd("post_flush2", 5'd12, 5'd4, 64'h0, 64'h0, 2'b00);            @(negedge clk);
    // Hold when rd_en is low.
    idle();                                                                 @(negedge clk);
    check("hold_valid", {127'h0, rd_valid}, 128'h0);
    check("hold_data", rd_data, 128'h0);
    idle(); rd("pre_hold2", 5'd9, 5'd5, 64'h99, 64'h11, 2'b00);             @(negedge clk);
    idle();                                                                 @(negedge clk);
    check("hold_data2", rd_data, {64'h11, 64'h99});
    // Asynchronous reset mid-operation.
    idle(); wr0(5'd5, 64'h55);
            rd("pre_reset", 5'd5, 5'd11, 64'h55, 64'h1111, 2'b00);          @(negedge clk);
    idle(); wr0(5'd7, 64'h7); bset(5'd7);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", {127'h0, rd_valid}, 128'h0);
    check("async_data", rd_data, 128'h0);
    check("async_busy", {126'h0, rd_busy}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(); rd("after_areset", 5'd5, 5'd7, 64'h0, 64'h0, 2'b00);            @(negedge clk);
    idle(); rd("after_areset2", 5'd11, 5'd10, 64'h0, 64'h0, 2'b00);         @(negedge clk);
    idle();
    repeat (2) @(negedge clk);

    check("queue_drained", 128'(sb.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port integer register file for the next-generation CPU datapath.
- Provides NUM_RD registered read ports and two write ports with fixed priority.
- Read ports bypass same-cycle writes, so a read sees data written in the same cycle.
- A per-register busy scoreboard is maintained inside the block, so the issue logic can detect pending writebacks without separate state.

Parameters:
DATA_W, 64, register width in bits
NUM_REGS, 32, number of architectural registers (power of 2)
RA_W, 5, register address width; must equal log2(NUM_REGS)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 is hardwired to zero and never busy; 0 = register 0 is an ordinary register

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_rd_en  input  1  capture all read ports on this edge
i_rd_addr  input  NUM_RD*RA_W  read addresses; port k = bits [k*RA_W +: RA_W]
o_rd_data  output  NUM_RD*DATA_W  registered read data, port k = [k*DATA_W +: DATA_W]
o_rd_busy  output  NUM_RD  registered busy flag per read port
o_rd_valid  output  1  o_rd_data/o_rd_busy updated by the previous edge
i_wr0_en  input  1  write port 0 enable
i_wr0_addr  input  RA_W  write port 0 address
i_wr0_data  input  DATA_W  write port 0 data
i_wr1_en  input  1  write port 1 enable (higher priority)
i_wr1_addr  input  RA_W  write port 1 address
i_wr1_data  input  DATA_W  write port 1 data
i_busy_set_en  input  1  mark a destination register as pending
i_busy_set_addr  input  RA_W  register to mark
i_flush  input  1  clear all busy bits (pipeline flush)

Behaviour:
- Reset (async, i_rst_n=0):
  - all registers 0, all busy bits 0
  - o_rd_data = 0, o_rd_busy = 0, o_rd_valid = 0
  - reset asserted mid-operation discards any in-flight write or set on that edge
- Writes: applied at the rising edge.
  - wr0_en and wr1_en to the same address: wr1 data is stored.
  - Different addresses: both are stored.
  - With ZERO_REG=1, writes to address 0 are ignored.
- Read latency is 1 cycle.
  - On an edge with i_rd_en=1, o_rd_data[k] is loaded with the effective value of i_rd_addr[k].
  - Effective value is, in priority order: 0 if ZERO_REG=1 and the address is 0; else wr1_data if wr1 hits the address; else wr0_data if wr0 hits the address; else the stored value.
  - i_rd_en=0: o_rd_data and o_rd_busy hold their previous values.
  - o_rd_valid <= i_rd_en every edge.
- Busy scoreboard, per register, next value evaluated in this order:
  - i_flush=1 -> all busy bits 0 (dominates everything)
  - else busy_set hits the register -> 1 (set wins over a same-cycle writeback clear)
  - else any enabled write hits the register -> 0
  - else hold
  - With ZERO_REG=1, register 0 busy is constant 0 and set requests to it are ignored.
- o_rd_busy[k], loaded on an edge with i_rd_en=1:
  - equals the current busy bit of the address, cleared if a same-cycle write hits it (bypass-consistent);
  - a same-cycle set is NOT reflected, because that reader precedes the producer;
  - i_flush=1 forces 0;
  - address 0 with ZERO_REG=1 gives 0.
- Multiple read ports may address the same register; each receives identical data and busy.
- Register storage has no reset dependency other than the async reset; no X is ever presented on outputs after reset.

Test Plan:
- Reset then i_rd_en=1, addrs {3,7} -> next cycle o_rd_valid=1, o_rd_data={0,0}, o_rd_busy=2'b00.
- wr0 to r5 = 0xA5, the next cycle read r5 -> 0xA5; a same-cycle read of r5 with wr1 to r5 = 0x11 and wr0 to r5 = 0x22 -> read returns 0x11 and r5 holds 0x11 afterwards.
- ZERO_REG=1: wr0 to r0 = 0xFFFF, busy_set r0, then read r0 -> data 0, busy 0.
- busy_set r9, then read r9 -> o_rd_busy=1; same edge wr0 r9 = 0x9 with read r9 -> data 0x9, busy 0; busy_set r9 and write r9 on the same edge -> r9 remains busy.
- busy_set r4, r6 on consecutive cycles, then i_flush together with busy_set r8 -> all busy 0 including r8; a read in the flush cycle reports busy 0.
- Assert i_rst_n=0 asynchronously between edges after writes -> outputs 0 immediately; a following read of previously written registers returns 0.
